// File: rtl/router_pkg.sv
// router_pkg: shared constants and types for the packet router FIFO.
// Holds default sizes, header length-field position and tracker states.
package router_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Header length field occupies data[LEN_MSB:LEN_LSB]
    localparam int LEN_LSB = 2;
    localparam int LEN_MSB = DEF_WIDTH - 1;

    typedef enum logic {
        PT_IDLE = 1'b0,
        PT_BODY = 1'b1
    } pt_state_e;

endpackage

// File: rtl/router_pkt_tracker.sv
// router_pkt_tracker: follows packet framing on the FIFO read side.
// Ports: clk_i/rst_i/flush_i, rd_i (accepted read), lfd_i + len_i of the
// word read, pkt_active_o (in packet body), pkt_err_o (truncation pulse).
module router_pkt_tracker
    import router_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     rd_i,
    input  logic                     lfd_i,
    input  logic [WIDTH-LEN_LSB-1:0] len_i,
    output logic                     pkt_active_o,
    output logic                     pkt_err_o
);

    // Remaining count is length + 1 (parity byte), one bit wider than len
    localparam int CW = WIDTH - LEN_LSB + 1;

    pt_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PT_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= PT_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (rd_i) begin
                if (lfd_i) begin
                    // A header while in a body means the prior packet was cut short
                    err_q   <= (state_q == PT_BODY);
                    state_q <= PT_BODY;
                    cnt_q   <= {1'b0, len_i} + CW'(1);
                end else if (state_q == PT_BODY) begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= PT_IDLE;
                    end
                end
            end
        end
    end

    assign pkt_active_o = (state_q == PT_BODY);
    assign pkt_err_o    = err_q;

endmodule

// File: rtl/router_fifo_pkt.sv
// router_fifo_pkt: packet-aware synchronous FIFO with header flag per entry.
// Ports: clock/reset/soft_reset, write_enb/read_enb/lfd_state/data_in in;
// data_out/data_valid, full/empty/almost_full/count, pkt_active, pkt_err,
// timeout out. Macro ROUTER_FIFO_TIMEOUT_EN enables the stall flush.
module router_fifo_pkt
    import router_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AF_THRESH   = DEPTH - 2,
    parameter int TIMEOUT_CYC = 30
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     read_enb,
    input  logic                     lfd_state,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pkt_active,
    output logic                     pkt_err,
    output logic                     timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] data_out_q;
    logic             data_valid_q;
    logic [WIDTH:0]   rd_word;
    logic             rd_ok;
    logic             wr_ok;
    logic             flush;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign almost_full = (count_q >= CW'(AF_THRESH));
    assign count       = count_q;

    // Reads never fall through an empty FIFO; a read frees room for a write
    assign rd_ok   = read_enb && !empty;
    assign wr_ok   = write_enb && (!full || rd_ok);
    assign rd_word = mem_q[rd_ptr_q];

`ifdef ROUTER_FIFO_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC) + 1;

    logic [SW-1:0] stall_q;
    logic          timeout_q;
    logic          stall;

    assign stall = !empty && !rd_ok;

    // timeout_q is high during the TIMEOUT_CYC-th stalled cycle, then flushes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else if (flush) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall ? stall_q + SW'(1) : '0;
            timeout_q <= stall && (stall_q == SW'(TIMEOUT_CYC - 2));
        end
    end

    assign flush   = soft_reset || timeout_q;
    assign timeout = timeout_q;
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign flush              = soft_reset;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (wr_ok && !flush) begin
            mem_q[wr_ptr_q] <= {lfd_state, data_in};
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q      <= count_d;
            data_out_q   <= rd_ok ? rd_word[WIDTH-1:0] : '0;
            data_valid_q <= rd_ok;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

    router_pkt_tracker #(
        .WIDTH (WIDTH)
    ) u_tracker (
        .clk_i        (clock),
        .rst_i        (reset),
        .flush_i      (flush),
        .rd_i         (rd_ok),
        .lfd_i        (rd_word[WIDTH]),
        .len_i        (rd_word[WIDTH-1:LEN_LSB]),
        .pkt_active_o (pkt_active),
        .pkt_err_o    (pkt_err)
    );

endmodule

// File: tb/tb_router_fifo_pkt.sv
// tb_router_fifo_pkt: directed self-checking bench for router_fifo_pkt.
// Drives and samples 1 time unit after each rising clock edge.
module tb_router_fifo_pkt;

    logic       clock;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] count;
    logic       pkt_active;
    logic       pkt_err;
    logic       timeout;

    int total;
    int bad;

    router_fifo_pkt dut (
        .clock       (clock),
        .reset       (reset),
        .soft_reset  (soft_reset),
        .write_enb   (write_enb),
        .read_enb    (read_enb),
        .lfd_state   (lfd_state),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .pkt_active  (pkt_active),
        .pkt_err     (pkt_err),
        .timeout     (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic lfd);
        write_enb = 1'b1;
        data_in   = d;
        lfd_state = lfd;
        cyc();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic flush_fifo();
        soft_reset = 1'b1;
        cyc();
        soft_reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if ({empty, full, almost_full, data_valid, pkt_active, pkt_err, timeout} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=1000000",
                     {empty, full, almost_full, data_valid, pkt_active, pkt_err, timeout});
        end
        total++;
        if (count !== 5'd0 || data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_count got=%0d/%h exp=0/00", count, data_out);
        end
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_fill();
        flush_fifo();
        for (int i = 0; i < 16; i++) begin
            wr(8'h10 + 8'(i), 1'b0);
            total++;
            if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14)) begin
                bad++;
                $display("FAIL fill_%0d got=%0d/af%b exp=%0d/af%b",
                         i, count, almost_full, i + 1, (i + 1 >= 14));
            end
        end
        total++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            bad++;
            $display("FAIL fill_full got=%b%b exp=10", full, empty);
        end
        wr(8'hEE, 1'b0);
        total++;
        if (count !== 5'd16) begin
            bad++;
            $display("FAIL overflow_drop got=%0d exp=16", count);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp;
        read_enb  = 1'b1;
        write_enb = 1'b1;
        data_in   = 8'hAA;
        cyc();
        write_enb = 1'b0;
        read_enb  = 1'b0;
        total++;
        if (count !== 5'd16 || data_valid !== 1'b1 || data_out !== 8'h10) begin
            bad++;
            $display("FAIL full_rw got=%0d/%b/%h exp=16/1/10", count, data_valid, data_out);
        end
        read_enb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            exp = (i < 15) ? 8'h11 + 8'(i) : 8'hAA;
            total++;
            if (data_out !== exp || data_valid !== 1'b1) begin
                bad++;
                $display("FAIL drain_%0d got=%h/%b exp=%h/1", i, data_out, data_valid, exp);
            end
        end
        cyc();
        read_enb = 1'b0;
        total++;
        if (empty !== 1'b1 || data_valid !== 1'b0 || data_out !== 8'h00) begin
            bad++;
            $display("FAIL underflow got=%b/%b/%h exp=1/0/00", empty, data_valid, data_out);
        end
    endtask

    task automatic test_empty_rw();
        flush_fifo();
        read_enb  = 1'b1;
        write_enb = 1'b1;
        data_in   = 8'h55;
        cyc();
        write_enb = 1'b0;
        read_enb  = 1'b0;
        total++;
        if (count !== 5'd1 || data_valid !== 1'b0) begin
            bad++;
            $display("FAIL empty_rw got=%0d/%b exp=1/0", count, data_valid);
        end
        read_enb = 1'b1;
        cyc();
        read_enb = 1'b0;
        total++;
        if (data_out !== 8'h55 || data_valid !== 1'b1 || empty !== 1'b1) begin
            bad++;
            $display("FAIL empty_rw_read got=%h/%b/%b exp=55/1/1", data_out, data_valid, empty);
        end
    endtask

    task automatic test_packet();
        logic [7:0] pkt [5];
        pkt[0] = 8'h0D;
        pkt[1] = 8'h01;
        pkt[2] = 8'h02;
        pkt[3] = 8'h03;
        pkt[4] = 8'h04;
        flush_fifo();
        for (int i = 0; i < 5; i++) wr(pkt[i], i == 0);
        read_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++;
            if (pkt_active !== (i < 4) || pkt_err !== 1'b0 || data_out !== pkt[i]) begin
                bad++;
                $display("FAIL packet_%0d got=act%b/err%b/%h exp=act%b/err0/%h",
                         i, pkt_active, pkt_err, data_out, (i < 4), pkt[i]);
            end
        end
        read_enb = 1'b0;
        cyc();
        total++;
        if (pkt_active !== 1'b0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL packet_end got=%b/%b exp=0/1", pkt_active, empty);
        end
    endtask

    task automatic test_pkt_err();
        logic [7:0] w [7];
        logic       l [7];
        logic       exp_act [7];
        logic       exp_err [7];
        // header len 5, two bytes, header len 2, three bytes
        w[0] = 8'h14; w[1] = 8'hA1; w[2] = 8'hA2; w[3] = 8'h08;
        w[4] = 8'hB1; w[5] = 8'hB2; w[6] = 8'hB3;
        for (int i = 0; i < 7; i++) begin
            l[i]       = (i == 0 || i == 3);
            exp_act[i] = (i < 6);
            exp_err[i] = (i == 3);
        end
        flush_fifo();
        for (int i = 0; i < 7; i++) wr(w[i], l[i]);
        read_enb = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            total++;
            if (pkt_active !== exp_act[i] || pkt_err !== exp_err[i]) begin
                bad++;
                $display("FAIL pkt_err_%0d got=act%b/err%b exp=act%b/err%b",
                         i, pkt_active, pkt_err, exp_act[i], exp_err[i]);
            end
        end
        read_enb = 1'b0;
        cyc();
    endtask

    task automatic test_soft_reset();
        flush_fifo();
        wr(8'h0D, 1'b1);
        wr(8'h01, 1'b0);
        wr(8'h02, 1'b0);
        read_enb = 1'b1;
        cyc();
        read_enb = 1'b0;
        total++;
        if (pkt_active !== 1'b1) begin
            bad++;
            $display("FAIL sreset_pre got=%b exp=1", pkt_active);
        end
        soft_reset = 1'b1;
        read_enb   = 1'b1;
        write_enb  = 1'b1;
        data_in    = 8'h77;
        cyc();
        soft_reset = 1'b0;
        read_enb   = 1'b0;
        write_enb  = 1'b0;
        total++;
        if (count !== 5'd0 || empty !== 1'b1 || data_valid !== 1'b0 ||
            data_out !== 8'h00 || pkt_active !== 1'b0) begin
            bad++;
            $display("FAIL sreset got=%0d/%b/%b/%h/%b exp=0/1/0/00/0",
                     count, empty, data_valid, data_out, pkt_active);
        end
    endtask

    task automatic test_timeout();
        int n;
        int seen;
        flush_fifo();
        n    = 0;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            write_enb = (k < 3);
            data_in   = 8'h30 + 8'(k);
            if (!empty && !read_enb) n++;
`ifdef ROUTER_FIFO_TIMEOUT_EN
            if (timeout === 1'b1) begin
                seen++;
                total++;
                if (n !== 30) begin
                    bad++;
                    $display("FAIL timeout_cycle got=%0d exp=30", n);
                end
                cyc();
                write_enb = 1'b0;
                total++;
                if (empty !== 1'b1 || timeout !== 1'b0 || count !== 5'd0) begin
                    bad++;
                    $display("FAIL timeout_flush got=%b/%b/%0d exp=1/0/0", empty, timeout, count);
                end
                break;
            end
`else
            if (timeout !== 1'b0) seen++;
`endif
            cyc();
        end
        write_enb = 1'b0;
        total++;
`ifdef ROUTER_FIFO_TIMEOUT_EN
        if (seen !== 1) begin
            bad++;
            $display("FAIL timeout_seen got=%0d exp=1", seen);
        end
`else
        if (seen !== 0 || count !== 5'd3) begin
            bad++;
            $display("FAIL timeout_off got=%0d/%0d exp=0/3", seen, count);
        end
`endif
    endtask

    task automatic test_reset_midpkt();
        flush_fifo();
        wr(8'h0D, 1'b1);
        wr(8'h01, 1'b0);
        wr(8'h02, 1'b0);
        read_enb = 1'b1;
        cyc();
        read_enb = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (empty !== 1'b1 || pkt_active !== 1'b0 || count !== 5'd0) begin
            bad++;
            $display("FAIL reset_midpkt got=%b/%b/%0d exp=1/0/0", empty, pkt_active, count);
        end
        cyc();
        reset = 1'b0;
        wr(8'h05, 1'b0);
        read_enb = 1'b1;
        cyc();
        read_enb = 1'b0;
        total++;
        if (pkt_active !== 1'b0 || data_out !== 8'h05) begin
            bad++;
            $display("FAIL after_reset got=%b/%h exp=0/05", pkt_active, data_out);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        test_reset();
        test_fill();
        test_full_rw();
        test_empty_rw();
        test_packet();
        test_pkt_err();
        test_soft_reset();
        test_timeout();
        test_reset_midpkt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
